// File: rtl/rf_sched_pkg.sv
// Shared widths and the write-back request bundle for the register-file write scheduler.
package rf_sched_pkg;

  localparam int unsigned NREQ_DEFAULT  = 3;
  localparam int unsigned WIDTH_DEFAULT = 32;
  localparam int unsigned REG_ADDR_W    = 5;
  localparam int unsigned NUM_REGS      = 32;
  // Bundle data field is sized for the widest supported register; narrower WIDTHs zero-extend into it.
  localparam int unsigned DATA_W_MAX    = 64;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    reg_addr_t             addr;
    logic [DATA_W_MAX-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rf_write_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer, pointer moves past the winner.
module rr_arbiter
  import rf_sched_pkg::*;
#(
  parameter int unsigned N = NREQ_DEFAULT,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt_c,
  output logic [IDX_W-1:0] gnt_idx_c
);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;
  logic [IDX_W-1:0] cur;
  logic             found;

  always_comb begin
    gnt_c     = '0;
    gnt_idx_c = '0;
    found     = 1'b0;
    cur       = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cur = IDX_W'((32'(ptr_q) + k) % N);
      if (!found && req[cur]) begin
        found      = 1'b1;
        gnt_c[cur] = 1'b1;
        gnt_idx_c  = cur;
      end
    end
    ptr_d = ptr_q;
    if (found) begin
      ptr_d = (gnt_idx_c == IDX_W'(N - 1)) ? '0 : gnt_idx_c + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/rf_write_scheduler.sv
// Register-file write-back scheduler: arbitrates write-back requesters onto one RF write port
// and keeps a busy scoreboard of destinations reserved at issue to flag read hazards.
module rf_write_scheduler
  import rf_sched_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT,
  parameter int unsigned NREQ  = NREQ_DEFAULT
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NREQ-1:0]                  req_valid,
  output logic [NREQ-1:0]                  req_ready,
  input  logic [NREQ-1:0][REG_ADDR_W-1:0]  req_addr,
  input  logic [NREQ-1:0][WIDTH-1:0]       req_data,
  output logic                             rf_we,
  output logic [REG_ADDR_W-1:0]            rf_waddr,
  output logic [WIDTH-1:0]                 rf_wdata,
  input  logic                             rsv_valid,
  input  logic [REG_ADDR_W-1:0]            rsv_addr,
  output logic                             rsv_ready,
  input  logic [REG_ADDR_W-1:0]            rd_addr1,
  input  logic [REG_ADDR_W-1:0]            rd_addr2,
  output logic                             hz1,
  output logic                             hz2
);

  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]       arb_req;
  logic [NREQ-1:0]       gnt_c;
  logic [IDX_W-1:0]      gnt_idx_c;
  wb_req_t               sel;
  logic                  fire;

  logic                  rf_we_q,    rf_we_d;
  logic [REG_ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [WIDTH-1:0]      rf_wdata_q, rf_wdata_d;
  logic [NUM_REGS-1:0]   busy_q,     busy_d;

  // Requests are masked during reset so nothing handshakes while state is being cleared.
  assign arb_req = req_valid & {NREQ{~rst}};

  rr_arbiter #(
    .N (NREQ)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (arb_req),
    .gnt_c     (gnt_c),
    .gnt_idx_c (gnt_idx_c)
  );

  assign req_ready = gnt_c;

  // Write-port stage: register 0 handshakes but never commits.
  always_comb begin
    sel        = '0;
    sel.addr   = req_addr[gnt_idx_c];
    sel.data   = DATA_W_MAX'(req_data[gnt_idx_c]);
    fire       = |gnt_c;
    rf_we_d    = fire && (sel.addr != '0);
    rf_waddr_d = fire ? sel.addr : rf_waddr_q;
    rf_wdata_d = fire ? WIDTH'(sel.data) : rf_wdata_q;
  end

  assign rsv_ready = ~rst & ~busy_q[rsv_addr];

  // Clear on commit, then set on reservation so a same-edge set wins.
  always_comb begin
    busy_d = busy_q;
    if (rf_we_q) begin
      busy_d[rf_waddr_q] = 1'b0;
    end
    if (rsv_valid && rsv_ready && (rsv_addr != '0)) begin
      busy_d[rsv_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      busy_q     <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      busy_q     <= busy_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign hz1      = busy_q[rd_addr1];
  assign hz2      = busy_q[rd_addr2];

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Scoreboard bench for rf_write_scheduler: directed scenarios plus randomized traffic against a reference model.
module tb_rf_write_scheduler;

  localparam int unsigned NREQ  = 3;
  localparam int unsigned WIDTH = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0][4:0]   req_addr;
  logic [NREQ-1:0][31:0]  req_data;
  logic                   rf_we;
  logic [4:0]             rf_waddr;
  logic [31:0]            rf_wdata;
  logic                   rsv_valid;
  logic [4:0]             rsv_addr;
  logic                   rsv_ready;
  logic [4:0]             rd_addr1;
  logic [4:0]             rd_addr2;
  logic                   hz1;
  logic                   hz2;

  rf_write_scheduler #(
    .WIDTH (WIDTH),
    .NREQ  (NREQ)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .rsv_ready (rsv_ready),
    .rd_addr1  (rd_addr1),
    .rd_addr2  (rd_addr2),
    .hz1       (hz1),
    .hz2       (hz2)
  );

  typedef struct {
    bit         we;
    logic [4:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model state
  int ptr       = 0;
  bit busy[32];
  bit pend_we   = 0;
  int pend_addr = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, req, $time);
  endtask

  task automatic idle_inputs();
    rst       = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    rsv_valid = 1'b0;
    rsv_addr  = '0;
    rd_addr1  = '0;
    rd_addr2  = '0;
  endtask

  task automatic begin_cycle();
    @(negedge clk);
    idle_inputs();
  endtask

  // Check combinational outputs for the inputs just driven, queue the expected write-back, advance the model.
  task automatic step();
    int         g;
    logic [2:0] erdy;
    bit         ersv;
    exp_t       e;
    bit         nb[32];
    #1;
    g = -1;
    if (!rst) begin
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (ptr + k) % NREQ;
        if (g < 0 && req_valid[i]) g = i;
      end
    end
    erdy = (g >= 0) ? 3'(1 << g) : 3'b000;
    ersv = !rst && !busy[rsv_addr];
    check("req_ready", 64'(req_ready), 64'(erdy));
    check("rsv_ready", 64'(rsv_ready), 64'(ersv));
    check("hz1", 64'(hz1), 64'(busy[rd_addr1]));
    check("hz2", 64'(hz2), 64'(busy[rd_addr2]));
    e.we   = (g >= 0) && (req_addr[g] != 5'd0);
    e.addr = (g >= 0) ? req_addr[g] : 5'd0;
    e.data = (g >= 0) ? req_data[g] : 32'd0;
    exp_q.push_back(e);
    if (rst) begin
      foreach (busy[j]) busy[j] = 1'b0;
      ptr     = 0;
      pend_we = 1'b0;
    end else begin
      nb = busy;
      if (pend_we) nb[pend_addr] = 1'b0;
      if (rsv_valid && ersv && rsv_addr != 5'd0) nb[rsv_addr] = 1'b1;
      busy      = nb;
      pend_we   = e.we;
      pend_addr = int'(e.addr);
      if (g >= 0) ptr = (g + 1) % NREQ;
    end
  endtask

  // Monitor: one expected write-back entry per cycle, compared after the edge that registers it.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rf_we", 64'(rf_we), 64'(e.we));
        if (e.we) begin
          check("rf_waddr", 64'(rf_waddr), 64'(e.addr));
          check("rf_wdata", 64'(rf_wdata), 64'(e.data));
        end
      end
    end
  end

  initial begin : stimulus
    foreach (busy[j]) busy[j] = 1'b0;
    idle_inputs();
    rst = 1'b1;

    // Reset with traffic present: nothing may handshake
    repeat (2) begin
      begin_cycle(); rst = 1'b1; req_valid = 3'b111; rsv_valid = 1'b1; rsv_addr = 5'd9; step();
    end

    // Single request
    begin_cycle(); req_valid = 3'b001; req_addr[0] = 5'd5; req_data[0] = 32'hDEADBEEF; step();
    begin_cycle(); step();

    // All requesters valid: rotating grants, back-to-back writes
    repeat (6) begin
      begin_cycle();
      req_valid = 3'b111;
      for (int i = 0; i < NREQ; i++) begin
        req_addr[i] = 5'(i + 1);
        req_data[i] = $urandom;
      end
      step();
    end

    // Reserve 7, re-reserve while busy, reserve 0, then write 7 and watch the hazard drop
    begin_cycle(); rsv_valid = 1'b1; rsv_addr = 5'd7; step();
    begin_cycle(); rsv_valid = 1'b1; rsv_addr = 5'd7; rd_addr1 = 5'd7; step();
    begin_cycle(); rsv_valid = 1'b1; rsv_addr = 5'd0; rd_addr1 = 5'd7; rd_addr2 = 5'd0; step();
    begin_cycle(); rd_addr1 = 5'd7; req_valid = 3'b010; req_addr[1] = 5'd7; req_data[1] = 32'h0000_7777; step();
    repeat (2) begin
      begin_cycle(); rd_addr1 = 5'd7; step();
    end

    // Write to register 0
    begin_cycle(); req_valid = 3'b100; req_addr[2] = 5'd0; req_data[2] = 32'h1234_5678; step();
    begin_cycle(); step();

    // Reset with busy bits and a live grant; arbitration restarts at requester 0
    begin_cycle(); rsv_valid = 1'b1; rsv_addr = 5'd3; step();
    begin_cycle(); rsv_valid = 1'b1; rsv_addr = 5'd4; req_valid = 3'b011; req_addr[0] = 5'd10; req_addr[1] = 5'd11; step();
    begin_cycle(); rst = 1'b1; req_valid = 3'b111; req_addr[1] = 5'd12; rd_addr1 = 5'd3; rd_addr2 = 5'd4; step();
    begin_cycle(); req_valid = 3'b111; req_addr[0] = 5'd13; req_data[0] = 32'hCAFE_0001; rd_addr1 = 5'd3; rd_addr2 = 5'd4; step();
    begin_cycle(); step();

    // Randomized traffic, addresses concentrated to force reservation/commit collisions
    for (int n = 0; n < 3000; n++) begin
      begin_cycle();
      rst       = ($urandom_range(0, 99) == 0);
      req_valid = 3'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        req_addr[i] = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
        req_data[i] = $urandom;
      end
      rsv_valid = 1'($urandom);
      rsv_addr  = 5'($urandom_range(0, 7));
      rd_addr1  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      rd_addr2  = 5'($urandom_range(0, 7));
      step();
    end

    begin_cycle(); step();
    @(posedge clk);
    #4;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
